// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM states, ACK/NACK line levels
// and byte width.
package i2c_pkg;

  localparam int   BYTE_W   = 8;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } state_t;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: multi-flop synchronizers followed by a one-cycle
// edge detector. Produces SCL edges, START/STOP events and synchronized SDA.
module i2c_line_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_prev_reg;
  logic                   sda_prev_reg;
  logic                   scl_s;

  // Synchronizer chains and previous-sample flops; reset to the idle-high bus
  // level so no edge is reported when reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda};
      scl_prev_reg <= scl_sync_reg[SYNC_STAGES-1];
      sda_prev_reg <= sda_sync_reg[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_prev_reg;
  assign scl_fall  = ~scl_s &  scl_prev_reg;
  // SDA may only move while SCL is steadily high for a START/STOP.
  assign start_det = scl_s & scl_prev_reg &  sda_prev_reg & ~sda_s;
  assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg &  sda_s;

endmodule

// File: rtl/i2c_slave_rw.sv
// I2C target with register pointer, write strobe port and combinational
// read port. Optional build macro: I2C_SLAVE_AUTO_INC_EN (pointer increments
// after every ACKed write byte and master-ACKed read byte).
module i2c_slave_rw
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h66,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam logic [3:0] BIT_LAST = 4'(BYTE_W);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] ptr_reg, ptr_next;
  logic       sda_out_reg, sda_out_next;   // 0 drives low, 1 releases
  logic       busy_reg, busy_next;
  logic       wr_valid_reg, wr_valid_next;
  logic [7:0] wr_addr_reg, wr_addr_next;
  logic [7:0] wr_data_reg, wr_data_next;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line_cond (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      ptr_reg      <= '0;
      sda_out_reg  <= 1'b1;
      busy_reg     <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shift_reg    <= shift_next;
      ptr_reg      <= ptr_next;
      sda_out_reg  <= sda_out_next;
      busy_reg     <= busy_next;
      wr_valid_reg <= wr_valid_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  // Next-state logic: START/STOP first, then bit sampling on SCL rise and
  // SDA changes on SCL fall.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shift_next    = shift_reg;
    ptr_next      = ptr_reg;
    sda_out_next  = sda_out_reg;
    busy_next     = busy_reg;
    wr_valid_next = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;

    if (start_det) begin
      state_next   = ADDR;
      cnt_next     = '0;
      sda_out_next = 1'b1;
    end else if (stop_det) begin
      state_next   = IDLE;
      sda_out_next = 1'b1;
      busy_next    = 1'b0;
    end else begin
      case (state_reg)
        ADDR, REG, WDATA: begin
          if (scl_rise && cnt_reg < BIT_LAST) begin
            shift_next = {shift_reg[6:0], sda_s};
            cnt_next   = cnt_reg + 4'd1;
          end else if (scl_fall && cnt_reg == BIT_LAST) begin
            cnt_next = '0;
            if (state_reg == ADDR) begin
              if (shift_reg[7:1] == DEV_ADDR) begin
                state_next   = ADDR_ACK;
                sda_out_next = I2C_ACK;
                busy_next    = 1'b1;
              end else begin
                state_next = IDLE;
                busy_next  = 1'b0;
              end
            end else if (state_reg == REG) begin
              ptr_next     = shift_reg;
              state_next   = REG_ACK;
              sda_out_next = I2C_ACK;
            end else begin
              state_next   = WDATA_ACK;
              sda_out_next = I2C_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_next = '0;
            if (shift_reg[0]) begin
              // Read: first data bit goes out on this same SCL fall.
              shift_next   = rd_data;
              sda_out_next = rd_data[7];
              state_next   = RDATA;
            end else begin
              sda_out_next = 1'b1;
              state_next   = REG;
            end
          end
        end
        REG_ACK: begin
          if (scl_fall) begin
            sda_out_next = 1'b1;
            cnt_next     = '0;
            state_next   = WDATA;
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            sda_out_next  = 1'b1;
            cnt_next      = '0;
            wr_valid_next = 1'b1;
            wr_addr_next  = ptr_reg;
            wr_data_next  = shift_reg;
`ifdef I2C_SLAVE_AUTO_INC_EN
            ptr_next      = ptr_reg + 8'd1;
`endif
            state_next    = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise && cnt_reg < BIT_LAST) begin
            cnt_next = cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (cnt_reg == BIT_LAST) begin
              sda_out_next = 1'b1;
              state_next   = RDATA_ACK;
            end else begin
              shift_next   = {shift_reg[6:0], 1'b0};
              sda_out_next = shift_reg[6];
            end
          end
        end
        RDATA_ACK: begin
          // Pointer moves at the ACK sample so rd_data is settled by the fall.
          if (scl_rise) begin
            if (sda_s == I2C_NACK) begin
              state_next = IDLE;
              busy_next  = 1'b0;
            end else begin
`ifdef I2C_SLAVE_AUTO_INC_EN
              ptr_next = ptr_reg + 8'd1;
`endif
            end
          end else if (scl_fall) begin
            shift_next   = rd_data;
            sda_out_next = rd_data[7];
            cnt_next     = '0;
            state_next   = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda      = sda_out_reg ? 1'bz : 1'b0;
  assign rd_addr  = ptr_reg;
  assign busy     = busy_reg;
  assign wr_valid = wr_valid_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;

endmodule

// File: tb/tb_i2c_slave_rw.sv
// Directed bench for i2c_slave_rw: bit-banged I2C master, register file
// model rd_data = rd_addr ^ 8'h5A, write-strobe monitor.
`timescale 1ns/1ps
module tb_i2c_slave_rw;

  localparam time Q = 80ns;   // quarter SCL period (8 clk)

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic       wr_valid;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] wr_q[$];

  pullup (sda);
  assign sda     = m_low ? 1'b0 : 1'bz;
  assign rd_data = rd_addr ^ 8'h5A;

  always #5 clk = ~clk;

  i2c_slave_rw dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_q.push_back({wr_addr, wr_data});
      $display("write strobe: addr=%h data=%h", wr_addr, wr_data);
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] q_at(input int i);
    if (i < wr_q.size()) return wr_q[i];
    return 16'h0000;
  endfunction

  task automatic put_bit(input logic b);
    m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic start_c;
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic stop_c;
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(ack);
    $display("master wrote %h, ack=%b", b, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      get_bit(bt);
      d[i] = bt;
    end
    put_bit(mack);
    $display("master read %h, sent %s", d, mack ? "NACK" : "ACK");
  endtask

  initial begin
    logic       a;
    logic [7:0] d1, d2;
    logic [7:0] pat;

    rst = 1'b1; scl = 1'b1; m_low = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #Q;
    chk("rst_sda",      16'(sda),      16'h0001);
    chk("rst_busy",     16'(busy),     16'h0000);
    chk("rst_wr_valid", 16'(wr_valid), 16'h0000);
    chk("rst_wr_addr",  16'(wr_addr),  16'h0000);
    chk("rst_wr_data",  16'(wr_data),  16'h0000);
    chk("rst_rd_addr",  16'(rd_addr),  16'h0000);

    // 1: single write
    start_c;
    wr_byte(8'hCC, a); chk("t1_ack_dev",  16'(a), 16'h0000);
    wr_byte(8'h81, a); chk("t1_ack_reg",  16'(a), 16'h0000);
    wr_byte(8'hB7, a); chk("t1_ack_data", 16'(a), 16'h0000);
    chk("t1_busy_on", 16'(busy), 16'h0001);
    stop_c; #Q;
    chk("t1_busy_off", 16'(busy), 16'h0000);
    chk("t1_nwr", 16'(wr_q.size()), 16'h0001);
    chk("t1_wr0", q_at(0), 16'h81B7);
    wr_q.delete();

    // 2: address mismatch
    start_c;
    wr_byte(8'hA0, a); chk("t2_ack_dev",  16'(a), 16'h0001);
    wr_byte(8'h81, a); chk("t2_ack_reg",  16'(a), 16'h0001);
    wr_byte(8'h55, a); chk("t2_ack_data", 16'(a), 16'h0001);
    chk("t2_busy", 16'(busy), 16'h0000);
    stop_c; #Q;
    chk("t2_nwr", 16'(wr_q.size()), 16'h0000);
    wr_q.delete();

    // 3: random read through repeated START
    start_c;
    wr_byte(8'hCC, a); chk("t3_ack_dev", 16'(a), 16'h0000);
    wr_byte(8'h10, a); chk("t3_ack_reg", 16'(a), 16'h0000);
    start_c;
    wr_byte(8'hCD, a); chk("t3_ack_rd", 16'(a), 16'h0000);
    rd_byte(1'b0, d1);
    rd_byte(1'b1, d2);
    chk("t3_byte0", 16'(d1), 16'h004A);
`ifdef I2C_SLAVE_AUTO_INC_EN
    chk("t3_byte1",  16'(d2),      16'h004B);
    chk("t3_rdaddr", 16'(rd_addr), 16'h0011);
`else
    chk("t3_byte1",  16'(d2),      16'h004A);
    chk("t3_rdaddr", 16'(rd_addr), 16'h0010);
`endif
    chk("t3_busy_nack", 16'(busy), 16'h0000);
    wr_byte(8'hCC, a); chk("t3_idle_noack", 16'(a), 16'h0001);
    stop_c; #Q;
    chk("t3_nwr", 16'(wr_q.size()), 16'h0000);
    wr_q.delete();

    // 4: burst write across the pointer wrap
    start_c;
    wr_byte(8'hCC, a); chk("t4_ack_dev", 16'(a), 16'h0000);
    wr_byte(8'hFF, a); chk("t4_ack_reg", 16'(a), 16'h0000);
    wr_byte(8'h01, a); chk("t4_ack_d0",  16'(a), 16'h0000);
    wr_byte(8'h02, a); chk("t4_ack_d1",  16'(a), 16'h0000);
    stop_c; #Q;
    chk("t4_nwr", 16'(wr_q.size()), 16'h0002);
    chk("t4_wr0", q_at(0), 16'hFF01);
`ifdef I2C_SLAVE_AUTO_INC_EN
    chk("t4_wr1",    q_at(1),      16'h0002);
    chk("t4_rdaddr", 16'(rd_addr), 16'h0001);
`else
    chk("t4_wr1",    q_at(1),      16'hFF02);
    chk("t4_rdaddr", 16'(rd_addr), 16'h00FF);
`endif
    wr_q.delete();

    // 5: STOP in the middle of a data byte
    start_c;
    wr_byte(8'hCC, a); chk("t5_ack_dev", 16'(a), 16'h0000);
    wr_byte(8'h20, a); chk("t5_ack_reg", 16'(a), 16'h0000);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    stop_c; #Q;
    chk("t5_busy", 16'(busy), 16'h0000);
    chk("t5_sda",  16'(sda),  16'h0001);
    wr_byte(8'hCC, a); chk("t5_idle_noack", 16'(a), 16'h0001);
    stop_c; #Q;
    chk("t5_nwr", 16'(wr_q.size()), 16'h0000);
    wr_q.delete();

    // 6: reset while the target holds the address ACK
    start_c;
    pat = 8'hCC;
    for (int i = 7; i >= 0; i--) put_bit(pat[i]);
    m_low = 1'b0; #Q;
    chk("t6_ack_held", 16'(sda),  16'h0000);
    chk("t6_busy_on",  16'(busy), 16'h0001);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_sda_rel", 16'(sda), 16'h0001);
    @(negedge clk); rst = 1'b0;
    chk("t6_busy",     16'(busy),     16'h0000);
    chk("t6_wr_valid", 16'(wr_valid), 16'h0000);
    chk("t6_wr_addr",  16'(wr_addr),  16'h0000);
    chk("t6_wr_data",  16'(wr_data),  16'h0000);
    chk("t6_rd_addr",  16'(rd_addr),  16'h0000);
    scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    stop_c; #Q;
    start_c;
    wr_byte(8'hCC, a); chk("t6_ack_dev",  16'(a), 16'h0000);
    wr_byte(8'h42, a); chk("t6_ack_reg",  16'(a), 16'h0000);
    wr_byte(8'h99, a); chk("t6_ack_data", 16'(a), 16'h0000);
    stop_c; #Q;
    chk("t6_nwr", 16'(wr_q.size()), 16'h0001);
    chk("t6_wr0", q_at(0), 16'h4299);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rw.md
Name: i2c_slave_rw

Overview:
- I2C target (slave) for the opposite end of the team's I2C master write path.
- Decodes START, 7-bit device address + R/W, an 8-bit register address, then data bytes.
- Writes are reported on a one-cycle strobe port. Reads fetch bytes from an external register file through a combinational read port.
- Lives in the peripheral island. SCL and SDA are oversampled in the `clk` domain; the block never stretches SCL.

Parameters:
- DEV_ADDR, 7'h66, 7-bit target address (8'hCD on the wire = read, 8'hCC = write).
- SYNC_STAGES, 2, synchronizer flops on the SCL and SDA inputs (≥2).

Ports:
- clk      input   1  system clock; SCL high and low phases each ≥ 8 clk cycles.
- rst      input   1  synchronous, active-high reset.
- scl      input   1  I2C clock from the master.
- sda      inout   1  open-drain data; block drives only 1'b0 or 1'bz.
- wr_valid output  1  one-cycle strobe: a data byte was received and ACKed.
- wr_addr  output  8  register address for wr_data.
- wr_data  output  8  received data byte.
- rd_addr  output  8  current register pointer, continuously driven.
- rd_data  input   8  register contents at rd_addr (combinational, valid same cycle).
- busy     output  1  high from an address-matched START until STOP or NACK-idle.

Behaviour:
- Reset state: sda released (z), wr_valid=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, FSM=IDLE. Reset takes effect at any point in a transfer, including mid-byte and while driving ACK; SDA is released on the next clk edge.
- Input conditioning: SYNC_STAGES-flop synchronizers, then 1-cycle edge detect on the synchronized SCL/SDA.
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
- Sampling and driving:
  - SDA is sampled on SCL rising edge, MSB first.
  - The block changes SDA only on SCL falling edge, plus 1 clk.
- START or repeated START, from any state: bit counter cleared, FSM → ADDR, a read shift in progress is aborted.
- STOP, from any state: FSM → IDLE, SDA released, busy=0.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- ADDR (8 bits):
  - Match on addr[7:1]==DEV_ADDR: drive ACK (SDA=0) from the SCL fall after bit 8 to the SCL fall after bit 9. busy=1.
  - Mismatch: no ACK, FSM → IDLE until the next START.
- After ADDR_ACK:
  - R/W=0 → REG.
  - R/W=1 → load shift register from rd_data, → RDATA.
- REG: 8 bits into the pointer (rd_addr), ACK, → WDATA.
- WDATA: 8 bits, then ACK.
  - At the SCL fall ending the ACK: wr_valid=1 for exactly 1 clk, with wr_addr=pointer and wr_data=byte.
  - Pointer update per AUTO_INC_EN. Stay in WDATA for further bytes.
- RDATA: shift out 8 bits (a 0 bit drives low, a 1 bit releases SDA), release SDA for the master ACK bit, sample it on SCL rise.
  - Master ACK (0): update pointer, reload from rd_data, continue.
  - Master NACK (1): → IDLE, busy=0.
- Pointer arithmetic: 8-bit, wraps 8'hFF → 8'h00.
- START and STOP never coincide with an SCL edge in the same clk, because they require SCL high. The START/STOP check has priority over bit sampling.

Optional Feature:
- Macro: I2C_SLAVE_AUTO_INC_EN.
- Defined: pointer increments by 1 after each ACKed write byte and each master-ACKed read byte, wrapping at 8'hFF.
- Undefined: pointer holds the REG value for the whole transaction. Burst writes all target one register; burst reads repeat the same byte.

Decomposition:
- Package i2c_pkg: FSM state enum, I2C_ACK=1'b0, I2C_NACK=1'b1, byte width constant 8.
- Sub-module i2c_line_cond: synchronizers plus edge detect for both lines. Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
1. Write: START, 8'hCC ACK, 8'h81 ACK, 8'hB7 ACK, STOP → one wr_valid pulse with wr_addr=8'h81 and wr_data=8'hB7; SDA low during all three ACK bits; busy returns to 0 after STOP.
2. Address mismatch: START, 8'hA0, 8'h81, 8'h55, STOP → SDA never driven, no wr_valid, busy stays 0.
3. Random read: write 8'h10 as the register, repeated START, 8'hCD, rd_data model returns addr^8'h5A, master ACK then NACK:
   - with AUTO_INC_EN: bytes 8'h4A, 8'h4B.
   - without AUTO_INC_EN: 8'h4A, 8'h4A.
   - FSM is IDLE after the NACK.
4. Burst write wrap: register 8'hFF, data 8'h01, 8'h02 → with AUTO_INC_EN: (FF,01) then (00,02); without: (FF,01) then (FF,02).
5. Mid-byte STOP: STOP after 4 bits of WDATA → no wr_valid, FSM IDLE, SDA released.
6. Reset mid-ACK: assert rst while the block holds SDA low → SDA released within 1 clk, all outputs at reset values, a following full write completes correctly.
